// File: rtl/servo_pkg.sv
// Shared constants and types for the servo motion blocks.
// The default frame and pulse limits are also used by the servo PWM block.
package servo_pkg;

    localparam int unsigned DEF_PERIOD     = 2000000;
    localparam int unsigned DEF_MIN_PULSE  = 50000;
    localparam int unsigned DEF_MAX_PULSE  = 250000;
    localparam int unsigned DEF_HOME_PULSE = 150000;

    localparam logic [7:0] ADDR_TARGET = 8'h00;
    localparam logic [7:0] ADDR_STEP   = 8'h04;
    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h0C;
    localparam logic [7:0] ADDR_CUR    = 8'h10;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        ARM  = 2'd1,
        RAMP = 2'd2,
        HOLD = 2'd3
    } servo_state_e;

endpackage

// File: rtl/servo_frame_timer.sv
// Frame timer: one-cycle tick every PERIOD clocks, first tick PERIOD cycles after reset.
// Implemented as a reloading down-counter with a terminal-count compare.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD = DEF_PERIOD
) (
    input  logic i_pclk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] C_RELOAD = W'(PERIOD - 1);

    logic [W-1:0] r_remain;

    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_remain <= C_RELOAD;
        end else if (r_remain == '0) begin
            r_remain <= C_RELOAD;
        end else begin
            r_remain <= r_remain - W'(1);
        end
    end

    assign o_tick = (r_remain == '0);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Slew-limited servo position sequencer: moves cur one STEP toward target per frame
// and issues each new pulse width as a one-cycle servo write.
//
//   state | meaning
//   OFF   | ticks ignored, pulse stopped
//   ARM   | enabled, waiting for first frame tick
//   RAMP  | stepping cur toward target each tick
//   HOLD  | cur == target, idle until target moves
module servo_ramp_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD     = DEF_PERIOD,
    parameter int unsigned MIN_PULSE  = DEF_MIN_PULSE,
    parameter int unsigned MAX_PULSE  = DEF_MAX_PULSE,
    parameter int unsigned HOME_PULSE = DEF_HOME_PULSE
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        bus_write_en,
    input  logic        bus_read_en,
    input  logic        ctrl_en,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic        servo_we,
    output logic [31:0] servo_wdata,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] C_MIN  = MIN_PULSE;
    localparam logic [31:0] C_MAX  = MAX_PULSE;
    localparam logic [31:0] C_HOME = HOME_PULSE;

    servo_state_e r_state;
    logic [31:0]  r_cur;
    logic [31:0]  r_target;
    logic [31:0]  r_step;
    logic         r_ctrl_en;
    logic         r_servo_we;
    logic [31:0]  r_servo_wdata;
    logic         r_done;

    logic         w_tick;
    logic         w_wr;
    logic         w_rd;
    logic         w_wr_target;
    logic         w_wr_step;
    logic         w_wr_ctrl;
    logic         w_disable;
    logic         w_enable;
    logic         w_act;
    logic         w_busy;
    logic [31:0]  w_target_clamped;
    logic [32:0]  w_sum;
    logic [32:0]  w_dif;
    logic [31:0]  w_next_cur;

    servo_frame_timer #(
        .PERIOD (PERIOD)
    ) u_frame_timer (
        .i_pclk  (pclk),
        .i_reset (reset),
        .o_tick  (w_tick)
    );

    assign w_wr        = bus_write_en & ctrl_en;
    assign w_rd        = bus_read_en & ctrl_en;
    assign w_wr_target = w_wr && (bus_addr == ADDR_TARGET);
    assign w_wr_step   = w_wr && (bus_addr == ADDR_STEP);
    assign w_wr_ctrl   = w_wr && (bus_addr == ADDR_CTRL);

    assign w_disable = w_wr_ctrl && !bus_write_data[0] && (r_state != OFF);
    assign w_enable  = w_wr_ctrl &&  bus_write_data[0] && (r_state == OFF);
    // HOLD with cur == target is the only non-OFF state that lets a tick pass silently.
    assign w_act     = w_tick && (r_state != OFF) && !((r_state == HOLD) && (r_cur == r_target));
    assign w_busy    = (r_state == ARM) || (r_state == RAMP);

    assign w_target_clamped = (bus_write_data < C_MIN) ? C_MIN :
                              (bus_write_data > C_MAX) ? C_MAX : bus_write_data;

    // 33-bit add/subtract so large STEP values saturate at target instead of wrapping.
    assign w_sum = {1'b0, r_cur} + {1'b0, r_step};
    assign w_dif = {1'b0, r_cur} - {1'b0, r_step};

    always_comb begin
        w_next_cur = r_target;
        if (r_step != '0) begin
            if (r_cur < r_target) begin
                if (w_sum < {1'b0, r_target}) begin
                    w_next_cur = w_sum[31:0];
                end
            end else if (r_cur > r_target) begin
                if (!w_dif[32] && (w_dif > {1'b0, r_target})) begin
                    w_next_cur = w_dif[31:0];
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state       <= OFF;
            r_cur         <= C_HOME;
            r_target      <= C_HOME;
            r_step        <= '0;
            r_ctrl_en     <= 1'b0;
            r_servo_we    <= 1'b0;
            r_servo_wdata <= '0;
            r_done        <= 1'b0;
        end else begin
            r_servo_we <= 1'b0;
            r_done     <= 1'b0;

            if (w_wr_target) begin
                r_target <= w_target_clamped;
            end
            if (w_wr_step) begin
                r_step <= bus_write_data;
            end
            if (w_wr_ctrl) begin
                r_ctrl_en <= bus_write_data[0];
            end

            // Disable beats a coincident tick; a zero-width write stops the pulse.
            if (w_disable) begin
                r_state       <= OFF;
                r_servo_we    <= 1'b1;
                r_servo_wdata <= '0;
            end else if (w_act) begin
                r_cur         <= w_next_cur;
                r_servo_we    <= 1'b1;
                r_servo_wdata <= w_next_cur;
                r_done        <= (w_next_cur == r_target);
                r_state       <= (w_next_cur == r_target) ? HOLD : RAMP;
            end else if (w_enable) begin
                r_state <= ARM;
            end
        end
    end

    always_comb begin
        bus_read_data = '0;
        if (w_rd) begin
            case (bus_addr)
                ADDR_TARGET: bus_read_data = r_target;
                ADDR_STEP:   bus_read_data = r_step;
                ADDR_CTRL:   bus_read_data = {31'd0, r_ctrl_en};
                ADDR_STATUS: bus_read_data = {w_busy, 29'd0, r_state};
                ADDR_CUR:    bus_read_data = r_cur;
                default:     bus_read_data = '0;
            endcase
        end
    end

    assign servo_we    = r_servo_we;
    assign servo_wdata = r_servo_wdata;
    assign done        = r_done;
    assign busy        = w_busy;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Bench for servo_ramp_ctrl: directed bus scenarios plus a per-cycle comparison
// against a frame-level behavioural model of the ramp rules.
module tb_servo_ramp_ctrl;

    localparam int PER   = 100;
    localparam int PMIN  = 10;
    localparam int PMAX  = 50;
    localparam int PHOME = 30;

    logic        pclk;
    logic        reset;
    logic        bus_write_en;
    logic        bus_read_en;
    logic        ctrl_en;
    logic [7:0]  bus_addr;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        servo_we;
    logic [31:0] servo_wdata;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nwr   = 0;
    bit chk_on = 0;

    servo_ramp_ctrl #(
        .PERIOD     (PER),
        .MIN_PULSE  (PMIN),
        .MAX_PULSE  (PMAX),
        .HOME_PULSE (PHOME)
    ) dut (
        .pclk           (pclk),
        .reset          (reset),
        .bus_write_en   (bus_write_en),
        .bus_read_en    (bus_read_en),
        .ctrl_en        (ctrl_en),
        .bus_addr       (bus_addr),
        .bus_write_data (bus_write_data),
        .bus_read_data  (bus_read_data),
        .servo_we       (servo_we),
        .servo_wdata    (servo_wdata),
        .busy           (busy),
        .done           (done)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 off, 1 armed, 2 ramping, 3 holding
    typedef struct packed {
        longint cur;
        longint tgt;
        longint stp;
        int     mode;
        int     cnt;
        bit     we;
        longint wd;
        bit     dn;
    } mstate_t;

    mstate_t m;

    function automatic longint approach(input longint c, input longint t, input longint s);
        if (c == t || s == 0) return t;
        if (c < t) return (t - c <= s) ? t : c + s;
        return (c - t <= s) ? t : c - s;
    endfunction

    function automatic longint clamp(input longint v);
        if (v < PMIN) return PMIN;
        if (v > PMAX) return PMAX;
        return v;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input bit rst, input bit wr,
                                           input bit [7:0] a, input bit [31:0] d);
        mstate_t n;
        longint  nv;
        bit      tick;
        bit      acts;
        n    = s;
        n.we = 0;
        n.dn = 0;
        if (rst) begin
            n.cnt = 0; n.mode = 0; n.cur = PHOME; n.tgt = PHOME; n.stp = 0; n.wd = 0;
            return n;
        end
        tick  = (s.cnt == PER - 1);
        n.cnt = (s.cnt + 1) % PER;
        acts  = tick && (s.mode == 1 || s.mode == 2 || (s.mode == 3 && s.cur != s.tgt));
        if (wr && a == 8'h08 && d[0] == 1'b0 && s.mode != 0) begin
            n.mode = 0; n.we = 1; n.wd = 0;
        end else if (acts) begin
            nv     = approach(s.cur, s.tgt, s.stp);
            n.cur  = nv;
            n.we   = 1;
            n.wd   = nv;
            n.dn   = (nv == s.tgt);
            n.mode = (nv == s.tgt) ? 3 : 2;
        end else if (wr && a == 8'h08 && d[0] == 1'b1 && s.mode == 0) begin
            n.mode = 1;
        end
        if (wr) begin
            if (a == 8'h00) n.tgt = clamp(longint'(d));
            if (a == 8'h04) n.stp = longint'(d);
        end
        return n;
    endfunction

    always @(posedge pclk)
        m <= model_next(m, reset === 1'b1, (bus_write_en === 1'b1) && (ctrl_en === 1'b1),
                        bus_addr, bus_write_data);

    // ---------------- clock, cycle count, per-cycle compare ----------------
    initial begin
        pclk = 0;
        forever #5 pclk = ~pclk;
    end

    initial forever begin
        @(posedge pclk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(negedge pclk);
        if (chk_on) begin
            total++;
            if (servo_we !== m.we || servo_wdata !== 32'(m.wd) || done !== m.dn ||
                busy !== (m.mode == 1 || m.mode == 2)) begin
                bad++;
                $display("FAIL cycle_check cyc=%0d we=%b/%b wdata=%0d/%0d done=%b/%b busy=%b/%b (dut/model)",
                         cyc, servo_we, m.we, servo_wdata, m.wd, done, m.dn, busy,
                         (m.mode == 1 || m.mode == 2));
            end
            if (servo_we === 1'b1) nwr++;
        end
    end

    // ---------------- helpers (called and returning at a falling edge) ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        bus_write_en = 1; ctrl_en = 1; bus_addr = a; bus_write_data = d;
        @(negedge pclk);
        bus_write_en = 0; ctrl_en = 0; bus_addr = 0; bus_write_data = 0;
    endtask

    task automatic bus_rd(input string nm, input logic [7:0] a, input logic [31:0] exp);
        bus_read_en = 1; ctrl_en = 1; bus_addr = a;
        #1;
        chk(nm, bus_read_data, exp);
        bus_read_en = 0; ctrl_en = 0; bus_addr = 0;
        @(negedge pclk);
    endtask

    task automatic wait_write(input string nm, input int budget, output logic [31:0] d,
                              output logic dn, output int at);
        d = '0; dn = 0; at = -1;
        for (int i = 0; i < budget; i++) begin
            if (servo_we === 1'b1) begin
                d = servo_wdata; dn = done; at = cyc;
                @(negedge pclk);
                return;
            end
            @(negedge pclk);
        end
        total++; bad++;
        $display("FAIL %s: no servo write within %0d cycles", nm, budget);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (m.cnt != v) begin
            @(negedge pclk);
            n++;
            if (n > 2 * PER) begin
                total++; bad++;
                $display("FAIL wait_cnt: frame position %0d never reached", v);
                return;
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        repeat (n) @(negedge pclk);
        reset = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [31:0] d;
        logic        dn;
        int          at, at0, n0, c0;
        int          exp6 [5];
        exp6 = '{34, 30, 26, 22, 20};

        reset = 1; bus_write_en = 0; bus_read_en = 0; ctrl_en = 0;
        bus_addr = 0; bus_write_data = 0;
        @(negedge pclk);
        chk_on = 1;
        chk("reset_we", {31'd0, servo_we}, 0);
        chk("reset_wdata", servo_wdata, 0);
        @(negedge pclk);
        reset = 0;

        // 1: idle after reset
        repeat (300) @(negedge pclk);
        chk("idle_no_writes", nwr, 0);
        bus_rd("idle_status", 8'h0C, 0);
        bus_rd("idle_cur", 8'h10, 30);
        bus_rd("idle_target", 8'h00, 30);
        bus_rd("unmapped_read", 8'h14, 0);
        ctrl_en = 0; bus_read_en = 1; bus_addr = 8'h10;
        #1 chk("read_unselected", bus_read_data, 0);
        bus_read_en = 0; bus_addr = 0;
        @(negedge pclk);

        // 2: ramp 30 -> 40 with STEP 4
        bus_wr(8'h04, 4);
        bus_wr(8'h00, 40);
        bus_wr(8'h08, 1);
        bus_rd("ctrl_readback", 8'h08, 1);
        bus_rd("armed_status", 8'h0C, 32'h8000_0001);
        wait_write("ramp_w1", 2 * PER, d, dn, at0);
        chk("ramp_w1_data", d, 34);
        chk("ramp_w1_done", {31'd0, dn}, 0);
        bus_rd("ramp_status", 8'h0C, 32'h8000_0002);
        wait_write("ramp_w2", 2 * PER, d, dn, at);
        chk("ramp_w2_data", d, 38);
        chk("ramp_w2_gap", at - at0, PER);
        wait_write("ramp_w3", 2 * PER, d, dn, at);
        chk("ramp_w3_data", d, 40);
        chk("ramp_w3_done", {31'd0, dn}, 1);
        chk("ramp_w3_gap", at - at0, 2 * PER);
        n0 = nwr;
        repeat (250) @(negedge pclk);
        chk("hold_no_writes", nwr - n0, 0);
        bus_rd("hold_status", 8'h0C, 3);
        bus_rd("hold_cur", 8'h10, 40);
        chk("model_cur_40", 32'(m.cur), 40);

        // 3: target clamping, restored before the next tick
        wait_cnt(2);
        bus_wr(8'h00, 5);
        bus_rd("clamp_low", 8'h00, 10);
        bus_wr(8'h00, 1000);
        bus_rd("clamp_high", 8'h00, 50);
        bus_rd("step_readback", 8'h04, 4);
        bus_wr(8'h00, 40);

        // 4: unlimited step jumps straight to target
        bus_wr(8'h04, 0);
        bus_wr(8'h00, 12);
        wait_write("jump_w", 2 * PER, d, dn, at);
        chk("jump_data", d, 12);
        chk("jump_done", {31'd0, dn}, 1);
        bus_rd("jump_status", 8'h0C, 3);
        bus_rd("jump_cur", 8'h10, 12);
        chk("model_cur_12", 32'(m.cur), 12);

        // 5: disable mid-ramp, then resume
        do_reset(2);
        bus_wr(8'h04, 4);
        bus_wr(8'h00, 40);
        bus_wr(8'h08, 1);
        wait_write("dis_w1", 2 * PER, d, dn, at);
        chk("dis_w1_data", d, 34);
        repeat (10) @(negedge pclk);
        bus_wr(8'h08, 0);
        chk("dis_zero_we", {31'd0, servo_we}, 1);
        chk("dis_zero_data", servo_wdata, 0);
        @(negedge pclk);
        chk("dis_we_one_cycle", {31'd0, servo_we}, 0);
        bus_rd("dis_status", 8'h0C, 0);
        bus_rd("dis_cur", 8'h10, 34);
        bus_wr(8'h08, 1);
        wait_write("resume_w", 2 * PER, d, dn, at);
        chk("resume_data", d, 38);

        // reset mid-ramp
        repeat (20) @(negedge pclk);
        do_reset(1);
        chk("rst_mid_we", {31'd0, servo_we}, 0);
        bus_rd("rst_mid_cur", 8'h10, 30);
        bus_rd("rst_mid_status", 8'h0C, 0);
        bus_rd("rst_mid_step", 8'h04, 0);

        // 6: target change in the tick cycle
        bus_wr(8'h04, 4);
        bus_wr(8'h00, 40);
        bus_wr(8'h08, 1);
        wait_write("tk_w0", 2 * PER, d, dn, at);
        chk("tk_w0_data", d, 34);
        wait_cnt(PER - 1);
        bus_wr(8'h00, 20);
        wait_write("tk_w1", 1, d, dn, at);
        chk("tk_old_target_used", d, 38);
        for (int i = 0; i < 5; i++) begin
            wait_write("tk_down", 2 * PER, d, dn, at);
            chk("tk_down_data", d, exp6[i]);
            chk("tk_down_done", {31'd0, dn}, (i == 4) ? 1 : 0);
        end
        bus_rd("tk_status", 8'h0C, 3);

        // enable in the tick cycle waits a whole frame
        bus_wr(8'h08, 0);
        bus_wr(8'h00, 24);
        wait_cnt(PER - 1);
        bus_wr(8'h08, 1);
        c0 = cyc;
        chk("en_tick_no_write", {31'd0, servo_we}, 0);
        wait_write("en_tick_w", 2 * PER, d, dn, at);
        chk("en_tick_data", d, 24);
        chk("en_tick_done", {31'd0, dn}, 1);
        chk("en_tick_latency", at - c0, PER);

        // disable in the tick cycle wins over the step
        bus_wr(8'h00, 40);
        wait_write("dt_w", 2 * PER, d, dn, at);
        chk("dt_w_data", d, 28);
        wait_cnt(PER - 1);
        bus_wr(8'h08, 0);
        chk("dt_zero_we", {31'd0, servo_we}, 1);
        chk("dt_zero_data", servo_wdata, 0);
        @(negedge pclk);
        n0 = nwr;
        repeat (150) @(negedge pclk);
        chk("dt_no_more_writes", nwr - n0, 0);
        bus_rd("dt_status", 8'h0C, 0);
        bus_rd("dt_cur", 8'h10, 28);

        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/servo_ramp_ctrl.md
# servo_ramp_ctrl

Slew-limited motion sequencer that sits between the processor bus and the `servo` PWM block. It holds a target pulse width and a per-period step, and on each servo period boundary moves the current pulse width one step toward the target. Each new value is issued as a one-cycle write on the servo's `bus_write_en` / `servo_en` / `bus_write_data` inputs. Software commands a position and polls status; the block guarantees no PWM jump larger than STEP clocks per frame.

## Interface
Parameters:
- `PERIOD`, 2000000: servo frame length in pclk cycles; must equal the servo's period.
- `MIN_PULSE`, 50000: lower clamp for the target, in clocks.
- `MAX_PULSE`, 250000: upper clamp for the target, in clocks.
- `HOME_PULSE`, 150000: reset value of the current and target pulse widths.

Ports:
- `pclk`  in  1: clock; one clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `bus_write_en`  in  1: processor write strobe.
- `bus_read_en`  in  1: processor read strobe.
- `ctrl_en`  in  1: chip select for this block.
- `bus_addr`  in  8: register address.
- `bus_write_data`  in  32: write data.
- `bus_read_data`  out  32: read data; combinational, 0 when not selected.
- `servo_we`  out  1: one-cycle write pulse, drives the servo's write_en and servo_en.
- `servo_wdata`  out  32: pulse width written to the servo.
- `busy`  out  1: 1 in ARM or RAMP.
- `done`  out  1: one-cycle pulse when current first equals target.

## Operation
Registers are decoded when `bus_write_en & ctrl_en`:
- 0x00 TARGET: the write is clamped to [MIN_PULSE, MAX_PULSE] before it is stored.
- 0x04 STEP: stored as written; STEP = 0 means unlimited, so the value jumps straight to target.
- 0x08 CTRL: bit0 = enable.
- 0x0C STATUS (read-only): bit31 = busy, bits[1:0] = state.
- 0x10 CUR (read-only).
- Unmapped reads return 0.

Period counter:
- 0..PERIOD-1, free-running from reset.
- `tick` is asserted when the counter equals PERIOD-1.

FSM states:
- OFF (0): no ticks are acted on.
- ARM (1): entered on enable rising (bit0 written 1 while in OFF).
- RAMP (2): entered on a tick while cur ≠ target.
- HOLD (3): entered on a tick once cur equals target.

Actions on a tick in ARM, RAMP or HOLD-with-cur≠target:
- If cur < target: cur ← min(cur+STEP, target).
- If cur > target: cur ← max(cur−STEP, target).
- If STEP = 0: cur ← target.
- In all cases, issue a servo write with the new cur.
- An ARM tick with cur == target still writes cur once, then the FSM goes to HOLD.
- `done` pulses together with the servo write that makes cur == target.
- A TARGET write in HOLD takes the FSM to RAMP on the next tick.

Arithmetic and width rules:
- Add and subtract in 33 bits; no wrap-around.
- cur is always within [MIN_PULSE, MAX_PULSE] ∪ {HOME_PULSE}.

Disable (CTRL bit0 written 0 in any non-OFF state):
- State → OFF.
- One servo write with data 0 on the next cycle, which stops the pulse.
- cur is retained.
- Re-enable goes to ARM and resumes from cur.

## Timing
- Reset values: `servo_we` = 0, `servo_wdata` = 0, `busy` = 0, `done` = 0, state = OFF, counter = 0, cur = target = HOME_PULSE, STEP = 0, CTRL = 0.
- Reset asserted mid-ramp returns the block to these values on the next edge, with no servo write.
- The first tick occurs PERIOD cycles after reset deassert.
- `servo_we`, `servo_wdata` and `done` are registered and assert the cycle after the tick. Their width is exactly 1 cycle.
- Register writes take effect at the next edge.
- Simultaneous events:
  - A TARGET or STEP write in the tick cycle: the old value is used for that tick.
  - A disable in the tick cycle: disable wins; only the 0-write is issued.
  - An enable in the tick cycle: ARM waits for the next tick.
- At most one servo write per cycle.
- Enable-to-first-write latency is at most PERIOD cycles.

## Structure
- Shared package `servo_pkg`:
  - register address constants (0x00–0x10);
  - the state enum {OFF, ARM, RAMP, HOLD};
  - the default PERIOD, MIN_PULSE, MAX_PULSE and HOME_PULSE constants, which the servo block also uses.
- One sub-module, `servo_frame_timer`: the period counter producing `tick`. It is reusable by other frame-synchronous blocks.
- The ramp step (clamp, add/subtract, saturate) is combinational logic inside the top-level module.

## Test plan
Bench parameters: PERIOD=100, MIN=10, MAX=50, HOME=30.

1. Reset with no writes for 300 cycles → `servo_we` never asserts; STATUS = 0; CUR = 30.
2. Write STEP=4, TARGET=40, then CTRL=1 → servo writes 34, 38, 40, one per frame, each 1 cycle after the tick. `done` pulses with the 40 write, then HOLD with no further writes.
3. Write TARGET=5 → reads back 10. Write TARGET=1000 → reads back 50.
4. From HOLD at 40, write STEP=0 and TARGET=12 → a single write of 12 at the next tick, with `done`.
5. Disable mid-ramp (cur = 34) → a write of 0 the next cycle; state OFF; CUR = 34. Re-enable → ramp resumes at 38.
6. TARGET=20 written exactly in the tick cycle while ramping toward 40 → that tick moves toward 40. The following ticks move toward 20.
